// File: rtl/edge_detector.sv
// Per-bit level edge detector: optional input synchronizer followed by a
// 4-state Moore FSM that emits one-cycle rising, falling and any-edge pulses.
module edge_detector #(
   parameter int unsigned WIDTH       = 1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] p_edge,
   output logic [WIDTH-1:0] n_edge,
   output logic [WIDTH-1:0] any_edge
);

   // One-hot so every output is a direct flop bit; unused codes recover to LOW.
   typedef enum logic [3:0] {
      LOW  = 4'b0001,
      RISE = 4'b0010,
      HIGH = 4'b0100,
      FALL = 4'b1000
   } state_t;

   logic [WIDTH-1:0] s;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = level;
      end else begin : g_sync
         logic [WIDTH-1:0] stage [SYNC_STAGES];

         // Synchronizer shift register, cleared on reset.
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int j = 0; j < int'(SYNC_STAGES); j++) begin
                  stage[j] <= '0;
               end
            end else begin
               stage[0] <= level;
               for (int j = 1; j < int'(SYNC_STAGES); j++) begin
                  stage[j] <= stage[j-1];
               end
            end
         end

         assign s = stage[SYNC_STAGES-1];
      end
   endgenerate

   generate
      for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
         state_t state;
         state_t state_nxt;

         // State register.
         always_ff @(posedge clk) begin
            if (reset) begin
               state <= LOW;
            end else begin
               state <= state_nxt;
            end
         end

         // Next-state logic; any illegal code falls back to LOW.
         always_comb begin
            state_nxt = LOW;
            case (state)
               LOW:     state_nxt = s[i] ? RISE : LOW;
               RISE:    state_nxt = s[i] ? HIGH : FALL;
               HIGH:    state_nxt = s[i] ? HIGH : FALL;
               FALL:    state_nxt = s[i] ? RISE : LOW;
               default: state_nxt = LOW;
            endcase
         end

         // Moore outputs decoded from the registered state only.
         assign p_edge[i]   = (state == RISE);
         assign n_edge[i]   = (state == FALL);
         assign any_edge[i] = (state == RISE) | (state == FALL);
      end
   endgenerate

endmodule

// File: tb/tb_edge_detector.sv
// Bench for edge_detector: a 4-bit, 2-stage-synchronized instance and a
// 1-bit unsynchronized instance, checked against a level-history model.
module tb_edge_detector;

   logic       clk;
   logic       reset;
   logic [3:0] level_a;
   logic [3:0] p_a, n_a, any_a;
   logic [0:0] level_b;
   logic [0:0] p_b, n_b, any_b;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] ap;
      logic [3:0] an;
      logic       bp;
      logic       bn;
   } exp_t;

   exp_t sb_q[$];

   // Reference history: two sync stages and previous FSM sample.
   logic [3:0] msync0, msync1, mprev;
   logic       bprev;

   edge_detector #(.WIDTH(4), .SYNC_STAGES(2)) dut_a (
      .clk      (clk),
      .reset    (reset),
      .level    (level_a),
      .p_edge   (p_a),
      .n_edge   (n_a),
      .any_edge (any_a)
   );

   edge_detector #(.WIDTH(1), .SYNC_STAGES(0)) dut_b (
      .clk      (clk),
      .reset    (reset),
      .level    (level_b),
      .p_edge   (p_b),
      .n_edge   (n_b),
      .any_edge (any_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle, push the expected output, then pop and compare after the edge.
   task automatic cycle(input logic rst, input logic [3:0] la, input logic lb);
      exp_t       e;
      logic [3:0] s;
      @(negedge clk);
      reset      = rst;
      level_a    = la;
      level_b[0] = lb;
      e = '0;
      if (rst) begin
         msync0 = '0;
         msync1 = '0;
         mprev  = '0;
         bprev  = 1'b0;
      end else begin
         s      = msync1;
         msync1 = msync0;
         msync0 = la;
         e.ap   = s & ~mprev;
         e.an   = ~s & mprev;
         mprev  = s;
         e.bp   = lb & ~bprev;
         e.bn   = ~lb & bprev;
         bprev  = lb;
      end
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check("sb_empty", 4'd1, 4'd0);
      end else begin
         e = sb_q.pop_front();
         check("a_p_edge",   p_a,   e.ap);
         check("a_n_edge",   n_a,   e.an);
         check("a_any_edge", any_a, e.ap | e.an);
         check("b_p_edge",   {3'b000, p_b},   {3'b000, e.bp});
         check("b_n_edge",   {3'b000, n_b},   {3'b000, e.bn});
         check("b_any_edge", {3'b000, any_b}, {3'b000, e.bp | e.bn});
      end
   endtask

   task automatic hold(input logic rst, input logic [3:0] la, input logic lb, input int n);
      for (int k = 0; k < n; k++) begin
         cycle(rst, la, lb);
      end
   endtask

   initial begin
      reset   = 1'b1;
      level_a = '0;
      level_b = '0;
      msync0  = '0;
      msync1  = '0;
      mprev   = '0;
      bprev   = 1'b0;

      // Reset hold, then quiet.
      hold(1'b1, 4'h0, 1'b0, 2);
      hold(1'b0, 4'h0, 1'b0, 5);

      // Rising edge on bit 0, held high; then falling edge.
      hold(1'b0, 4'h1, 1'b0, 6);
      hold(1'b0, 4'h0, 1'b0, 5);

      // Reset mid-operation, then a clean rise and fall.
      hold(1'b1, 4'h0, 1'b0, 1);
      hold(1'b0, 4'h0, 1'b0, 1);
      hold(1'b0, 4'h1, 1'b0, 5);
      hold(1'b0, 4'h0, 1'b0, 5);

      // Reset while an edge is in the pipeline and level stays high.
      hold(1'b0, 4'h1, 1'b1, 1);
      hold(1'b1, 4'h1, 1'b1, 1);
      hold(1'b0, 4'h1, 1'b1, 5);
      hold(1'b0, 4'h0, 1'b0, 5);

      // One-cycle glitches on both instances.
      hold(1'b0, 4'h1, 1'b1, 1);
      hold(1'b0, 4'h0, 1'b0, 5);

      // Multi-bit: 0000 -> 0101 -> 0011 -> 0000.
      hold(1'b0, 4'h5, 1'b0, 4);
      hold(1'b0, 4'h3, 1'b1, 4);
      hold(1'b0, 4'h0, 1'b0, 4);

      // Random traffic with occasional resets.
      for (int k = 0; k < 80; k++) begin
         cycle(($urandom_range(0, 19) == 0), 4'($urandom), 1'($urandom));
      end
      hold(1'b0, 4'h0, 1'b0, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/edge_detector.md
Name: edge_detector

Overview:
- Synchronous edge detector for a `WIDTH`-bit level bus.
- Each bit has an optional input synchronizer and a 4-state Moore FSM.
- Each bit produces single-cycle rising-edge, falling-edge and any-edge pulses.
- Used between slow or asynchronous level signals (buttons, status lines) and control logic that needs one-cycle event strobes.

Parameters:
- `WIDTH`, 1, number of independent level bits; each has its own FSM.
- `SYNC_STAGES`, 2, flip-flop synchronizer depth on `level`. Legal 0..3; 0 means `level` is sampled directly by the FSM.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  reset, synchronous, active-high; clears synchronizers, FSMs and outputs.
- `level`  input  `WIDTH`  level inputs; may be asynchronous when `SYNC_STAGES` ≥ 2.
- `p_edge`  output  `WIDTH`  bit i high for exactly one cycle after a 0→1 transition of `level[i]`.
- `n_edge`  output  `WIDTH`  bit i high for exactly one cycle after a 1→0 transition of `level[i]`.
- `any_edge`  output  `WIDTH`  equals `p_edge | n_edge`, bitwise.

Behaviour:
- Interface rule: one clock; reset is synchronous and active-high.
- Reset is sampled on the rising edge of `clk`. While `reset` = 1:
  - all synchronizer flops go to 0;
  - every FSM goes to LOW;
  - `p_edge` = `n_edge` = `any_edge` = 0 from the first clock edge with `reset` high.
- Synchronizer: a `SYNC_STAGES`-deep shift register per bit. Sample s[i] is the last stage, or `level[i]` directly when `SYNC_STAGES` = 0.
- Per-bit Moore FSM, states LOW, RISE, HIGH, FALL. Encoding is free but must be one-hot or binary with no illegal-state lockup. Any unused encoding goes to LOW on the next clock.
  - LOW: s=1 → RISE; s=0 → LOW.
  - RISE: s=1 → HIGH; s=0 → FALL (a one-cycle high pulse still yields both pulses, back to back).
  - HIGH: s=0 → FALL; s=1 → HIGH.
  - FALL: s=1 → RISE; s=0 → LOW.
- Outputs are decoded purely from state, registered-equivalent and glitch-free:
  - `p_edge[i]` = (state==RISE);
  - `n_edge[i]` = (state==FALL);
  - `any_edge[i]` = `p_edge[i] | n_edge[i]`.
- Latency: a change of `level[i]` that is set up before clock edge k appears on the output from edge k+`SYNC_STAGES` and lasts exactly one cycle.
- A static level produces no pulses. A level held for N cycles produces exactly one pulse at entry and one at exit.
- After reset, the FSM is in LOW. If `level[i]` is already 1 when reset deasserts, a `p_edge[i]` pulse is generated (treated as a rising edge).
- Reset mid-operation:
  - any pulse in flight is cancelled;
  - the synchronizer contents are discarded;
  - an edge whose synchronized sample was still in the pipeline is lost, apart from the post-reset `level`=1 rule above.
- Bits are fully independent. Simultaneous edges on different bits produce simultaneous pulses.
- `p_edge[i]` and `n_edge[i]` are never high in the same cycle.

Test Plan:
- Reset hold: `reset`=1 for 2 cycles with `level`=0 → all outputs 0; after release with `level` held 0 for 5 cycles → outputs stay 0.
- Rising edge (`WIDTH`=1, `SYNC_STAGES`=2): `level` 0→1 before edge k → `p_edge`=1 and `any_edge`=1 for exactly the cycle after edge k+2; `n_edge`=0 throughout; no further pulse while `level` stays 1 for 5 cycles.
- Falling edge: from steady `level`=1, drive 0 → `n_edge`=1 and `any_edge`=1 for one cycle after 2-cycle latency; `p_edge`=0.
- Reset mid-operation: after `level` returns to 0, assert `reset` for 1 cycle, release, then raise `level` → single `p_edge` pulse; a second lowering gives a single `n_edge` pulse.
- One-cycle glitch (`SYNC_STAGES`=0): `level`=1 for one cycle only → `p_edge` then `n_edge` in consecutive cycles, each one cycle wide.
- Multi-bit (`WIDTH`=4): `level` 0000→0101 then →0011 → `p_edge`=0101 once, then `p_edge`=0010 together with `n_edge`=0100 in the same cycle.
